// File: rtl/digit_seq_ctrl_if.sv
// Command/status bundle for the digit sequencer: commands flow master -> slave,
// digit/status flow back. clk and reset are plain ports on the block.
interface digit_seq_ctrl_if;
    logic       start;
    logic       stop;
    logic       clear;
    logic       dir;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] max_digit;
    logic [3:0] digit;
    logic       tick;
    logic       wrap;
    logic       running;
    logic [1:0] state;

    modport master (
        output start, stop, clear, dir, load, load_val, max_digit,
        input  digit, tick, wrap, running, state
    );

    modport slave (
        input  start, stop, clear, dir, load, load_val, max_digit,
        output digit, tick, wrap, running, state
    );
endinterface

// File: rtl/digit_seq_ctrl.sv
// Digit sequencer: steps a 4-bit digit through 0..max_digit every PRESCALE
// cycles while running, with pause/resume, load and clear commands.
module digit_seq_ctrl #(
    parameter logic [23:0] PRESCALE = 24'd10_000_000
) (
    input  logic             clk,
    input  logic             reset,
    digit_seq_ctrl_if.slave  bus
);
    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] RUN   = 2'b01;
    localparam logic [1:0] PAUSE = 2'b10;

    logic [1:0]  state_q, state_d;
    logic [3:0]  digit_q, digit_d;
    logic [23:0] pre_cnt_q, pre_cnt_d;
    logic        tick_q, tick_d;
    logic        wrap_q, wrap_d;

    logic [3:0]  step_digit;
    logic        step_wrap;

    // Value the digit takes on a step, in the direction currently requested.
    always_comb begin
        step_digit = digit_q;
        step_wrap  = 1'b0;
        if (!bus.dir) begin
            if (digit_q >= bus.max_digit) begin
                step_digit = 4'd0;
                step_wrap  = 1'b1;
            end else begin
                step_digit = digit_q + 4'd1;
            end
        end else begin
            if (digit_q == 4'd0) begin
                step_digit = bus.max_digit;
                step_wrap  = 1'b1;
            end else if (digit_q > bus.max_digit) begin
                // Range shrank under us: clamp rather than wrap.
                step_digit = bus.max_digit;
            end else begin
                step_digit = digit_q - 4'd1;
            end
        end
    end

    // Next-state: one command acts per cycle (clear > load > stop > start);
    // with no blocking command, RUN advances the prescaler and steps on terminal count.
    always_comb begin
        state_d   = state_q;
        digit_d   = digit_q;
        pre_cnt_d = pre_cnt_q;
        tick_d    = 1'b0;
        wrap_d    = 1'b0;
        if (state_q != IDLE && state_q != RUN && state_q != PAUSE) begin
            state_d = IDLE;
        end else if (bus.clear) begin
            state_d   = IDLE;
            digit_d   = 4'd0;
            pre_cnt_d = 24'd0;
        end else if (bus.load) begin
            digit_d   = (bus.load_val > bus.max_digit) ? bus.max_digit : bus.load_val;
            pre_cnt_d = 24'd0;
        end else if (bus.stop) begin
            // Outside RUN a stop is simply ignored; pre_cnt and digit hold.
            if (state_q == RUN) state_d = PAUSE;
        end else begin
            if (bus.start && state_q != RUN) state_d = RUN;
            if (state_q == RUN) begin
                if (pre_cnt_q == PRESCALE - 24'd1) begin
                    pre_cnt_d = 24'd0;
                    digit_d   = step_digit;
                    tick_d    = 1'b1;
                    wrap_d    = step_wrap;
                end else begin
                    pre_cnt_d = pre_cnt_q + 24'd1;
                end
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            digit_q   <= 4'd0;
            pre_cnt_q <= 24'd0;
            tick_q    <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            digit_q   <= digit_d;
            pre_cnt_q <= pre_cnt_d;
            tick_q    <= tick_d;
            wrap_q    <= wrap_d;
        end
    end

    assign bus.digit   = digit_q;
    assign bus.tick    = tick_q;
    assign bus.wrap    = wrap_q;
    assign bus.state   = state_q;
    assign bus.running = (state_q == RUN);
endmodule

// File: tb/tb_digit_seq_ctrl.sv
// Bench for digit_seq_ctrl: a table of per-cycle vectors plus hand-written
// multi-cycle sequences; a second instance runs with PRESCALE=1.
module tb_digit_seq_ctrl;
    logic clk = 1'b0;
    logic rst4, rst1;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    digit_seq_ctrl_if b4 ();
    digit_seq_ctrl_if b1 ();

    digit_seq_ctrl #(.PRESCALE(24'd4)) dut4 (.clk(clk), .reset(rst4), .bus(b4));
    digit_seq_ctrl #(.PRESCALE(24'd1)) dut1 (.clk(clk), .reset(rst1), .bus(b1));

    typedef struct {
        logic       st, sp, cl, dr, ld;
        logic [3:0] lv, mx;
        logic [3:0] ed;
        logic       et, ew;
        logic [1:0] es;
    } vec_t;

    vec_t tbl [26];

    function automatic vec_t mk(logic st, logic sp, logic cl, logic dr, logic ld,
                                logic [3:0] lv, logic [3:0] mx, logic [3:0] ed,
                                logic et, logic ew, logic [1:0] es);
        vec_t v;
        v.st = st; v.sp = sp; v.cl = cl; v.dr = dr; v.ld = ld;
        v.lv = lv; v.mx = mx; v.ed = ed; v.et = et; v.ew = ew; v.es = es;
        return v;
    endfunction

    task automatic chk(string name, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive4(logic st, logic sp, logic cl, logic dr, logic ld,
                          logic [3:0] lv, logic [3:0] mx);
        b4.start = st; b4.stop = sp; b4.clear = cl; b4.dir = dr;
        b4.load = ld; b4.load_val = lv; b4.max_digit = mx;
    endtask

    task automatic reset4();
        rst4 = 1'b1;
        drive4(0, 0, 0, 0, 0, 4'd0, 4'd9);
        cyc();
        cyc();
        rst4 = 1'b0;
    endtask

    initial begin
        rst4 = 1'b1;
        rst1 = 1'b1;
        drive4(0, 0, 0, 0, 0, 4'd0, 4'd9);
        b1.start = 0; b1.stop = 0; b1.clear = 0; b1.dir = 0;
        b1.load = 0; b1.load_val = 4'd0; b1.max_digit = 4'd0;

        //            st sp cl dr ld lv     mx     digit  tk wr state
        tbl[0]  = mk(1, 0, 0, 0, 0, 4'd0,  4'd9, 4'd0, 0, 0, 2'b01);
        tbl[1]  = mk(0, 0, 0, 0, 0, 4'd0,  4'd9, 4'd0, 0, 0, 2'b01);
        tbl[2]  = mk(0, 0, 0, 0, 0, 4'd0,  4'd9, 4'd0, 0, 0, 2'b01);
        tbl[3]  = mk(0, 0, 0, 0, 0, 4'd0,  4'd9, 4'd0, 0, 0, 2'b01);
        tbl[4]  = mk(0, 0, 0, 0, 0, 4'd0,  4'd9, 4'd1, 1, 0, 2'b01);
        tbl[5]  = mk(0, 0, 0, 0, 0, 4'd0,  4'd9, 4'd1, 0, 0, 2'b01);
        tbl[6]  = mk(0, 0, 0, 0, 1, 4'd12, 4'd9, 4'd9, 0, 0, 2'b01);
        tbl[7]  = mk(0, 0, 0, 0, 0, 4'd0,  4'd9, 4'd9, 0, 0, 2'b01);
        tbl[8]  = mk(0, 0, 0, 0, 0, 4'd0,  4'd9, 4'd9, 0, 0, 2'b01);
        tbl[9]  = mk(0, 0, 0, 0, 0, 4'd0,  4'd9, 4'd9, 0, 0, 2'b01);
        tbl[10] = mk(0, 0, 0, 0, 0, 4'd0,  4'd9, 4'd0, 1, 1, 2'b01);
        tbl[11] = mk(0, 1, 0, 0, 0, 4'd0,  4'd9, 4'd0, 0, 0, 2'b10);
        tbl[12] = mk(0, 0, 0, 0, 0, 4'd0,  4'd9, 4'd0, 0, 0, 2'b10);
        tbl[13] = mk(1, 0, 0, 1, 0, 4'd0,  4'd9, 4'd0, 0, 0, 2'b01);
        tbl[14] = mk(0, 0, 0, 1, 0, 4'd0,  4'd9, 4'd0, 0, 0, 2'b01);
        tbl[15] = mk(0, 0, 0, 1, 0, 4'd0,  4'd9, 4'd0, 0, 0, 2'b01);
        tbl[16] = mk(0, 0, 0, 1, 0, 4'd0,  4'd9, 4'd0, 0, 0, 2'b01);
        tbl[17] = mk(0, 0, 0, 1, 0, 4'd0,  4'd9, 4'd9, 1, 1, 2'b01);
        tbl[18] = mk(0, 0, 0, 1, 0, 4'd0,  4'd5, 4'd9, 0, 0, 2'b01);
        tbl[19] = mk(0, 0, 0, 1, 0, 4'd0,  4'd5, 4'd9, 0, 0, 2'b01);
        tbl[20] = mk(0, 0, 0, 1, 0, 4'd0,  4'd5, 4'd9, 0, 0, 2'b01);
        tbl[21] = mk(0, 0, 0, 1, 0, 4'd0,  4'd5, 4'd5, 1, 0, 2'b01);
        tbl[22] = mk(1, 1, 1, 0, 0, 4'd0,  4'd9, 4'd0, 0, 0, 2'b00);
        tbl[23] = mk(0, 0, 0, 0, 1, 4'd3,  4'd9, 4'd3, 0, 0, 2'b00);
        tbl[24] = mk(0, 1, 0, 0, 1, 4'd4,  4'd9, 4'd4, 0, 0, 2'b00);
        tbl[25] = mk(0, 1, 0, 0, 0, 4'd0,  4'd9, 4'd4, 0, 0, 2'b00);

        // Reset state.
        reset4();
        chk("rst_digit",   b4.digit,   0);
        chk("rst_tick",    b4.tick,    0);
        chk("rst_wrap",    b4.wrap,    0);
        chk("rst_state",   b4.state,   0);
        chk("rst_running", b4.running, 0);

        // Table-driven per-cycle vectors.
        for (int i = 0; i < 26; i++) begin
            drive4(tbl[i].st, tbl[i].sp, tbl[i].cl, tbl[i].dr, tbl[i].ld, tbl[i].lv, tbl[i].mx);
            cyc();
            chk($sformatf("tbl%0d_digit", i), b4.digit, tbl[i].ed);
            chk($sformatf("tbl%0d_tick",  i), b4.tick,  tbl[i].et);
            chk($sformatf("tbl%0d_wrap",  i), b4.wrap,  tbl[i].ew);
            chk($sformatf("tbl%0d_state", i), b4.state, tbl[i].es);
            chk($sformatf("tbl%0d_run",   i), b4.running, (tbl[i].es == 2'b01) ? 1 : 0);
        end

        // Count up 0..9 and wrap, tick every 4 cycles.
        reset4();
        drive4(1, 0, 0, 0, 0, 4'd0, 4'd9);
        cyc();
        drive4(0, 0, 0, 0, 0, 4'd0, 4'd9);
        for (int c = 1; c <= 40; c++) begin
            int n;
            cyc();
            n = (c / 4) % 10;
            chk($sformatf("up%0d_digit", c), b4.digit, n);
            chk($sformatf("up%0d_tick",  c), b4.tick, (c % 4 == 0) ? 1 : 0);
            chk($sformatf("up%0d_wrap",  c), b4.wrap, (c % 4 == 0 && n == 0) ? 1 : 0);
        end

        // Count down with max_digit=5 from digit 0.
        reset4();
        drive4(1, 0, 0, 1, 0, 4'd0, 4'd5);
        cyc();
        drive4(0, 0, 0, 1, 0, 4'd0, 4'd5);
        for (int c = 1; c <= 28; c++) begin
            int n;
            cyc();
            n = c / 4;
            chk($sformatf("dn%0d_digit", c), b4.digit, (6 - (n % 6)) % 6);
            chk($sformatf("dn%0d_tick",  c), b4.tick, (c % 4 == 0) ? 1 : 0);
            chk($sformatf("dn%0d_wrap",  c), b4.wrap, (c % 4 == 0 && n % 6 == 1) ? 1 : 0);
        end

        // Pause at pre_cnt=2 for 10 cycles, then resume: tick 2 cycles later.
        reset4();
        drive4(1, 0, 0, 0, 0, 4'd0, 4'd9);
        cyc();
        drive4(0, 0, 0, 0, 0, 4'd0, 4'd9);
        cyc();
        cyc();
        drive4(0, 1, 0, 0, 0, 4'd0, 4'd9);
        for (int c = 0; c < 10; c++) begin
            cyc();
            chk("pause_state", b4.state, 2);
            chk("pause_tick",  b4.tick,  0);
            chk("pause_digit", b4.digit, 0);
        end
        drive4(1, 0, 0, 0, 0, 4'd0, 4'd9);
        cyc();
        drive4(0, 0, 0, 0, 0, 4'd0, 4'd9);
        chk("resume_state", b4.state, 1);
        chk("resume_tick0", b4.tick,  0);
        cyc();
        chk("resume_tick1", b4.tick,  0);
        cyc();
        chk("resume_tick2", b4.tick,  1);
        chk("resume_digit", b4.digit, 1);

        // Reset landing on the step edge.
        reset4();
        drive4(1, 0, 0, 0, 0, 4'd0, 4'd9);
        cyc();
        drive4(0, 0, 0, 0, 0, 4'd0, 4'd9);
        cyc();
        cyc();
        cyc();
        rst4 = 1'b1;
        cyc();
        chk("rststep_digit", b4.digit, 0);
        chk("rststep_tick",  b4.tick,  0);
        chk("rststep_state", b4.state, 0);
        rst4 = 1'b0;
        cyc();
        chk("rststep_idle",  b4.state, 0);
        chk("rststep_tick2", b4.tick,  0);

        // PRESCALE=1, max_digit=0: tick and wrap every RUN cycle.
        cyc();
        rst1 = 1'b0;
        b1.start = 1'b1;
        cyc();
        b1.start = 1'b0;
        chk("p1_state", b1.state, 1);
        chk("p1_tick0", b1.tick,  0);
        for (int c = 0; c < 5; c++) begin
            cyc();
            chk("p1_digit", b1.digit, 0);
            chk("p1_tick",  b1.tick,  1);
            chk("p1_wrap",  b1.wrap,  1);
            chk("p1_run",   b1.running, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/digit_seq_ctrl.md
DIGIT_SEQ_CTRL -- requirements
Module: digit_seq_ctrl

Interface
REQ-001 Parameter PRESCALE, default 24'd10_000_000: clock cycles per digit step; legal range 1..2^24-1.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  reset, synchronous, active-high; clock clk.
REQ-004 start  input  1  level; request to enter or resume RUN.
REQ-005 stop  input  1  level; request to pause.
REQ-006 clear  input  1  level; return to IDLE with digit 0.
REQ-007 dir  input  1  0 = count up, 1 = count down; sampled on each step.
REQ-008 load  input  1  one-cycle strobe; load digit from load_val.
REQ-009 load_val  input  4  value for load.
REQ-010 max_digit  input  4  inclusive upper limit of the digit range (0..max_digit).
REQ-011 digit  output  4  current digit, registered; feeds the 7-segment decoder.
REQ-012 tick  output  1  registered one-cycle pulse in the cycle digit takes a stepped value.
REQ-013 wrap  output  1  registered one-cycle pulse coincident with tick when the step wrapped.
REQ-014 running  output  1  high while in RUN.
REQ-015 state  output  2  encoded state: IDLE=00, RUN=01, PAUSE=10; 11 never driven.

Function
REQ-016 The block SHALL implement a 3-state FSM IDLE, RUN, PAUSE and a 24-bit prescaler counter pre_cnt.
REQ-017 Command priority SHALL be clear > load > stop > start; only the highest-priority active command acts in a cycle.
REQ-018 clear SHALL, in any state, set next state IDLE, digit 0, pre_cnt 0, tick 0, wrap 0.
REQ-019 load SHALL set digit to min(load_val, max_digit) and pre_cnt to 0; state unchanged; tick/wrap 0 that cycle.
REQ-020 stop in RUN SHALL enter PAUSE with pre_cnt and digit held; stop in IDLE or PAUSE SHALL have no effect.
REQ-021 start in IDLE or PAUSE SHALL enter RUN next cycle; start in RUN has no effect; PAUSE->RUN SHALL resume pre_cnt from its held value.
REQ-022 In RUN with no higher-priority command, pre_cnt SHALL increment each cycle; when pre_cnt == PRESCALE-1 it SHALL return to 0 and a step SHALL occur.
REQ-023 With PRESCALE=1 a step SHALL occur every RUN cycle.
REQ-024 Up step: digit >= max_digit -> 0 with wrap=1; else digit+1, wrap=0.
REQ-025 Down step: digit == 0 -> max_digit with wrap=1; digit > max_digit -> max_digit, wrap=0; else digit-1, wrap=0.
REQ-026 tick (and wrap when applicable) SHALL be high exactly in the cycle after the step edge, i.e. the cycle the new digit is visible; otherwise 0.
REQ-027 In IDLE and PAUSE, digit and pre_cnt SHALL hold except for clear/load.
REQ-028 A change of max_digit below the current digit SHALL NOT alter digit until the next step or load.
REQ-029 Step period in uninterrupted RUN SHALL be exactly PRESCALE cycles; first tick after IDLE->RUN SHALL appear PRESCALE cycles after the first RUN cycle.
REQ-030 running SHALL equal (state == RUN) combinationally from the state register.

Reset
REQ-031 While reset is high at a rising clk edge: state IDLE, digit 0, pre_cnt 0, tick 0, wrap 0, running 0.
REQ-032 reset SHALL override all commands, including mid-RUN and mid-step; operation resumes from IDLE the cycle after reset deasserts.

Verification (PRESCALE=4 unless stated)
REQ-033 reset, max_digit=9, dir=0, start 1 cycle -> tick every 4 cycles, digit 1,2..9,0; wrap only on the 9->0 tick.
REQ-034 dir=1, max_digit=5, start from digit 0 -> first tick digit=5 with wrap=1, then 4,3,2,1,0, then 5 with wrap=1.
REQ-035 RUN, stop when pre_cnt=2 for 10 cycles, then start -> state PAUSE, digit held, no tick; next tick 2 cycles after resume.
REQ-036 start, stop and clear together in RUN at digit 7 -> IDLE, digit 0, no tick; load_val=12 with max_digit=9 -> digit 9.
REQ-037 PRESCALE=1, max_digit=0, dir=0 -> digit stays 0, tick and wrap high every RUN cycle.
REQ-038 reset asserted in the cycle of a step -> digit 0, tick 0, state IDLE next cycle.
